// File: rtl/multimode_counter_if.sv
// Control and status bundle for multimode_counter: step/load controls in, registered count and flags out.
// The counter side takes the slave modport; whoever drives the controls takes master.
interface multimode_counter_if #(
    parameter int WIDTH = 4
);
    logic             Enable;
    logic             Load;
    logic [WIDTH-1:0] LoadValue;
    logic [1:0]       Mode;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Binary;
    logic             TerminalCount;
    logic             Wrap;

    modport master (
        output Enable, Load, LoadValue, Mode,
        input  Q, Binary, TerminalCount, Wrap
    );

    modport slave (
        input  Enable, Load, LoadValue, Mode,
        output Q, Binary, TerminalCount, Wrap
    );
endinterface

// File: rtl/multimode_counter.sv
// Up/down counter with parallel load and Gray/binary output. Build option: COUNTER_SATURATE_EN.
// Latency: every input change is visible on Q/Binary/TerminalCount/Wrap one Clock later.
// Backpressure: none; Enable low simply holds the count (Q encoding still tracks Mode).
module multimode_counter #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    multimode_counter_if.slave    cnt
);

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] q_q;
    logic             tc_q;
    logic             wrap_q;

    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;
    logic             wrap_nxt;
    logic             down;
    logic             gray;
    logic             at_end;

    assign down = cnt.Mode[0];
    assign gray = cnt.Mode[1];

    always_comb begin
        count_nxt = count_q;
        wrap_nxt  = 1'b0;
        // The end of range depends on direction, so a reversal re-targets it immediately.
        at_end    = down ? (count_q == ZERO) : (count_q == ALL_ONES);

        if (cnt.Load) begin
            count_nxt = cnt.LoadValue;
        end else if (cnt.Enable) begin
`ifdef COUNTER_SATURATE_EN
            if (!at_end) begin
                count_nxt = down ? (count_q - ONE) : (count_q + ONE);
            end
`else
            count_nxt = down ? (count_q - ONE) : (count_q + ONE);
            wrap_nxt  = at_end;
`endif
        end

        q_nxt  = gray ? (count_nxt ^ (count_nxt >> 1)) : count_nxt;
        tc_nxt = down ? (count_nxt == ZERO) : (count_nxt == ALL_ONES);
    end

    // Reset presents the raw binary reset value; encoding is applied from the first edge after.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= RESET_VALUE;
            q_q     <= RESET_VALUE;
            tc_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            q_q     <= q_nxt;
            tc_q    <= tc_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    assign cnt.Q             = q_q;
    assign cnt.Binary        = count_q;
    assign cnt.TerminalCount = tc_q;
    assign cnt.Wrap          = wrap_q;

endmodule

// File: tb/tb_multimode_counter.sv
// Bench for multimode_counter: integer reference model compared every cycle, directed literal
// scenarios, then randomized load/enable/mode/reset traffic.
module tb_multimode_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int RSTV = 0;

    logic Clock;
    logic Reset_n;

    multimode_counter_if #(.WIDTH(W)) bus ();

    multimode_counter #(.WIDTH(W), .RESET_VALUE(4'(RSTV))) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .cnt     (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int nchecks = 0;
    int nerrors = 0;
    bit check_en = 1'b0;

    // Reference state, plain integers
    int m_count, m_q, m_tc, m_wrap;
    int nxt, wr;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Reset_n) begin
        m_count = RSTV;
        m_q     = RSTV;
        m_tc    = 0;
        m_wrap  = 0;
    end

    always @(posedge Clock) begin
        if (Reset_n) begin
            nxt = m_count;
            wr  = 0;
            if (bus.Load) begin
                nxt = int'(bus.LoadValue);
            end else if (bus.Enable) begin
                if (bus.Mode[0]) begin
                    if (m_count == 0) begin
`ifdef COUNTER_SATURATE_EN
                        nxt = 0;
`else
                        nxt = MAXV;
                        wr  = 1;
`endif
                    end else nxt = m_count - 1;
                end else begin
                    if (m_count == MAXV) begin
`ifdef COUNTER_SATURATE_EN
                        nxt = MAXV;
`else
                        nxt = 0;
                        wr  = 1;
`endif
                    end else nxt = m_count + 1;
                end
            end
            m_count = nxt;
            m_q     = bus.Mode[1] ? (nxt ^ (nxt >> 1)) : nxt;
            m_tc    = bus.Mode[0] ? int'(nxt == 0) : int'(nxt == MAXV);
            m_wrap  = wr;
        end
        #1;
        if (check_en) begin
            chk("model_binary", int'(bus.Binary), m_count);
            chk("model_q", int'(bus.Q), m_q);
            chk("model_tc", int'(bus.TerminalCount), m_tc);
            chk("model_wrap", int'(bus.Wrap), m_wrap);
        end
    end

    task automatic drive(input bit en, input bit ld, input int lv, input int mode);
        @(negedge Clock);
        bus.Enable    = en;
        bus.Load      = ld;
        bus.LoadValue = 4'(lv);
        bus.Mode      = 2'(mode);
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    int gray_seq [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    int down_seq [6]  = '{4, 3, 2, 1, 0, 15};
    int prev_q;

    initial begin
        Reset_n       = 1'b0;
        bus.Enable    = 1'b0;
        bus.Load      = 1'b0;
        bus.LoadValue = '0;
        bus.Mode      = 2'b00;
        check_en      = 1'b1;
        repeat (2) @(negedge Clock);
        chk("reset_q", int'(bus.Q), 0);
        chk("reset_binary", int'(bus.Binary), 0);
        chk("reset_tc", int'(bus.TerminalCount), 0);
        chk("reset_wrap", int'(bus.Wrap), 0);

        // Binary up from reset
        @(negedge Clock);
        Reset_n = 1'b1;
`ifndef COUNTER_SATURATE_EN
        bus.Enable = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("up_q", int'(bus.Q), i % 16);
            chk("up_wrap", int'(bus.Wrap), int'(i == 16));
            chk("up_tc", int'(bus.TerminalCount), int'(i == 15));
        end

        // Gray up from 0, one bit change per step including the wrap
        drive(1, 1, 0, 2);
        tick();
        chk("gray_load_q", int'(bus.Q), 0);
        drive(1, 0, 0, 2);
        prev_q = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("gray_q", int'(bus.Q), gray_seq[i]);
            chk("gray_hamming", $countones(4'(bus.Q) ^ 4'(prev_q)), 1);
            prev_q = int'(bus.Q);
        end

        // Load beats Enable, then count down through the wrap
        drive(1, 1, 5, 0);
        tick();
        chk("load_binary", int'(bus.Binary), 5);
        chk("load_wrap", int'(bus.Wrap), 0);
        drive(1, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("down_q", int'(bus.Q), down_seq[i]);
            chk("down_wrap", int'(bus.Wrap), int'(i == 5));
            chk("down_tc", int'(bus.TerminalCount), int'(i == 4));
        end
`else
        drive(1, 1, 14, 0);
        tick();
        chk("sat_load", int'(bus.Binary), 14);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_q", int'(bus.Q), 15);
            chk("sat_wrap", int'(bus.Wrap), 0);
            chk("sat_tc", int'(bus.TerminalCount), 1);
        end
        drive(1, 1, 1, 1);
        tick();
        drive(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_down_q", int'(bus.Q), 0);
            chk("sat_down_wrap", int'(bus.Wrap), 0);
            chk("sat_down_tc", int'(bus.TerminalCount), 1);
        end
`endif

        // Mode change while holding re-encodes Q only
        drive(0, 1, 6, 0);
        tick();
        chk("hold_q_bin", int'(bus.Q), 6);
        drive(0, 0, 0, 2);
        tick();
        chk("hold_q_gray", int'(bus.Q), 5);
        chk("hold_binary", int'(bus.Binary), 6);

        // Asynchronous reset mid-count
        drive(0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0);
        repeat (9) tick();
        chk("pre_reset_binary", int'(bus.Binary), 9);
        @(negedge Clock);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_q", int'(bus.Q), 0);
        chk("async_binary", int'(bus.Binary), 0);
        chk("async_wrap", int'(bus.Wrap), 0);
        chk("async_tc", int'(bus.TerminalCount), 0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, MAXV)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 199) == 0) begin
                #2 Reset_n = 1'b0;
                @(negedge Clock);
                Reset_n = 1'b1;
            end
        end
        drive(0, 0, 0, 0);
        tick();
        check_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
